// File: rtl/stickman_motion_pkg.sv
// stickman_pkg: shared types and constants for the stickman motion engine.
//   motion_t   : jump state machine encoding
//   ST_*       : bit positions inside the one-hot game status word
//   KEY_SPACE  : keycode of the jump key
package stickman_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GROUNDED = 2'd1,
    RISING   = 2'd2,
    FALLING  = 2'd3
  } motion_t;

  localparam int ST_SELECT = 4;
  localparam int ST_WAIT   = 3;
  localparam int ST_PLAY   = 2;
  localparam int ST_WIN    = 1;
  localparam int ST_LOSE   = 0;

  localparam logic [7:0] KEY_SPACE = 8'h2C;

endpackage

// File: rtl/stickman_motion_if.sv
// stickman_motion_if: game-side bundle around the motion engine.
//   keycode     : last received key (8'h00 = none)
//   status      : one-hot game status (SELECT/WAIT/PLAY/WIN/LOSE)
//   GroundY     : ground row under the stickman column
//   StickmanTop : top row of the stickman
//   on_ground   : high while grounded
//   jump_pulse  : one-Clk pulse on a jump launch
// master = game side (drives inputs), slave = motion engine.
interface stickman_motion_if;
  import stickman_pkg::*;

  logic [7:0]        keycode;
  logic [ST_SELECT:0] status;
  logic [9:0]        GroundY;
  logic [9:0]        StickmanTop;
  logic              on_ground;
  logic              jump_pulse;

  modport master (
    output keycode, status, GroundY,
    input  StickmanTop, on_ground, jump_pulse
  );

  modport slave (
    input  keycode, status, GroundY,
    output StickmanTop, on_ground, jump_pulse
  );

endinterface

// File: rtl/stickman_motion_frame_tick.sv
// frame_tick_sync: brings the asynchronous ~60 Hz frame strobe into the Clk
// domain and produces a one-Clk tick per frame_clk rising edge.
//   Clk, Reset_n : system clock, synchronous active-low reset
//   frame_clk    : asynchronous frame strobe
//   tick         : registered one-Clk pulse per frame
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic s1, s2;

  // The edge pulse is registered so downstream sees a clean, glitch-free
  // strobe; the motion update therefore lands 3 Clk after the frame rise.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      tick <= 1'b0;
    end else begin
      s1   <= frame_clk;
      s2   <= s1;
      tick <= s1 & ~s2;
    end
  end

endmodule

// File: rtl/stickman_motion.sv
// stickman_motion: per-frame vertical motion engine for the stickman.
//   Clk, Reset_n : system clock, synchronous active-low reset
//   frame_clk    : asynchronous frame strobe, one update per rising edge
//   bus (slave)  : keycode/status/GroundY in, StickmanTop/on_ground/jump_pulse out
// Jump state machine with signed velocity, gravity, an air-jump budget and
// snap-to-ground landing. All position math is 11-bit signed and range
// checked before truncation to the 10-bit row.
module stickman_motion
  import stickman_pkg::*;
#(
  parameter logic [9:0] START_TOP = 10'd330,
  parameter logic [9:0] HEIGHT    = 10'd50,
  parameter logic [5:0] JUMP_V    = 6'd12,
  parameter logic [5:0] GRAVITY   = 6'd1,
  parameter logic [5:0] MAX_FALL  = 6'd12,
  parameter logic [9:0] MAX_TOP   = 10'd430,
  parameter logic [7:0] JUMP_KEY  = KEY_SPACE,
  parameter logic [1:0] AIR_JUMPS = 2'd1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  stickman_motion_if.slave  bus
);

  localparam logic signed [10:0] HEIGHT_S   = $signed({1'b0, HEIGHT});
  localparam logic signed [10:0] MAX_TOP_S  = $signed({1'b0, MAX_TOP});
  localparam logic signed [10:0] GRAVITY_S  = $signed({5'd0, GRAVITY});
  localparam logic signed [10:0] MAX_FALL_S = $signed({5'd0, MAX_FALL});
  localparam logic signed [6:0]  JUMP_V7    = $signed({1'b0, JUMP_V});
  localparam logic signed [6:0]  MAX_FALL7  = $signed({1'b0, MAX_FALL});

  logic              tick;
  motion_t           state, state_n;
  logic [9:0]        top, top_n;
  logic signed [6:0] vel, vel_n, vel_tmp;
  logic [1:0]        jumps_left, jumps_n;
  logic              jump_req, consume;
  logic              jump_pulse_q, pulse_n;
  logic [7:0]        key_prev;

  logic play, sel_wait, win_lose;
  logic signed [10:0] top_s, vel_s, new_top, new_bot, old_bot, gnd_s, snap, vel_sum;

  assign play     = bus.status[ST_PLAY];
  assign sel_wait = bus.status[ST_SELECT] | bus.status[ST_WAIT];
  assign win_lose = bus.status[ST_WIN]    | bus.status[ST_LOSE];

  frame_tick_sync u_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // Edge-detected jump request: a held key raises it only once. It survives
  // until a launch consumes it, so a press that cannot be serviced mid-air
  // launches on the first tick after landing.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      key_prev <= 8'h00;
      jump_req <= 1'b0;
    end else begin
      key_prev <= bus.keycode;
      if (!play)
        jump_req <= 1'b0;
      else if (bus.keycode == JUMP_KEY && key_prev != JUMP_KEY)
        jump_req <= 1'b1;
      else if (consume)
        jump_req <= 1'b0;
    end
  end

  // State register (also carries the motion datapath registers).
  always_ff @(posedge Clk) begin
    if (!Reset_n || sel_wait) begin
      state        <= IDLE;
      top          <= START_TOP;
      vel          <= 7'sd0;
      jumps_left   <= AIR_JUMPS;
      jump_pulse_q <= 1'b0;
    end else if (win_lose) begin
      jump_pulse_q <= 1'b0;
    end else begin
      state        <= state_n;
      top          <= top_n;
      vel          <= vel_n;
      jumps_left   <= jumps_n;
      jump_pulse_q <= pulse_n;
    end
  end

  always_comb begin
    top_s   = $signed({1'b0, top});
    vel_s   = $signed({{4{vel[6]}}, vel});
    gnd_s   = $signed({1'b0, bus.GroundY});
    new_top = top_s + vel_s;
    old_bot = top_s + HEIGHT_S;
    new_bot = new_top + HEIGHT_S;
    snap    = gnd_s - HEIGHT_S;
  end

  // Next-state logic: everything moves only on a tick while playing.
  always_comb begin
    state_n = state;
    top_n   = top;
    vel_n   = vel;
    jumps_n = jumps_left;
    pulse_n = 1'b0;
    consume = 1'b0;
    vel_tmp = vel;
    vel_sum = 11'sd0;
    if (tick && play) begin
      case (state)
        IDLE: state_n = GROUNDED;
        GROUNDED: begin
          // Jump wins over ground loss on the same tick.
          if (jump_req) begin
            state_n = RISING;
            vel_n   = -JUMP_V7;
            jumps_n = AIR_JUMPS;
            pulse_n = 1'b1;
            consume = 1'b1;
          end else if (old_bot < gnd_s) begin
            state_n = FALLING;
            vel_n   = 7'sd0;
          end
          // Ground above the bottom: hold; the game FSM flags the crash.
        end
        RISING, FALLING: begin
          if (jump_req && jumps_left != 2'd0) begin
            state_n = RISING;
            vel_n   = -JUMP_V7;
            jumps_n = jumps_left - 2'd1;
            pulse_n = 1'b1;
            consume = 1'b1;
          end else if (state == FALLING && old_bot <= gnd_s && new_bot >= gnd_s) begin
            // Crossed the ground line this frame: snap onto it.
            if (snap < 11'sd0)          top_n = 10'd0;
            else if (snap > MAX_TOP_S)  top_n = MAX_TOP;
            else                        top_n = snap[9:0];
            vel_n   = 7'sd0;
            state_n = GROUNDED;
          end else begin
            if (new_top < 11'sd0) begin
              top_n   = 10'd0;
              vel_tmp = 7'sd0;   // head hit the ceiling: kill upward speed
            end else if (new_top > MAX_TOP_S) begin
              top_n   = MAX_TOP;
            end else begin
              top_n   = new_top[9:0];
            end
            vel_sum = $signed({{4{vel_tmp[6]}}, vel_tmp}) + GRAVITY_S;
            vel_n   = (vel_sum > MAX_FALL_S) ? MAX_FALL7 : vel_sum[6:0];
            state_n = vel_n[6] ? RISING : FALLING;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Outputs.
  always_comb begin
    bus.StickmanTop = top;
    bus.on_ground   = (state == GROUNDED);
    bus.jump_pulse  = jump_pulse_q;
  end

endmodule
